// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer: default raster size,
// controller state encoding and the pixel-address width helper.
package fb_pkg;

    localparam int H_RES_DEF = 800;
    localparam int V_RES_DEF = 600;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } fb_state_e;

    // Bits needed to address every pixel of an h x v frame linearly.
    function automatic int pix_addr_w(input int h, input int v);
        return $clog2(h * v);
    endfunction

endpackage

// File: rtl/fb_pixel_writer_fifo.sv
// Parameterized first-word-fall-through FIFO (module fb_write_fifo); the head
// entry is visible on rdata_o whenever empty_o is low.
module fb_write_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: its contents are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Rasterizer pixel stream to double-buffered linear framebuffer writes.
// Optional FB_PIXEL_STATS_EN adds per-frame written/dropped counters.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = pix_addr_w(H_RES_DEF, V_RES_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic [10:0]       in_x,
    input  logic [10:0]       in_y,
    input  logic              in_draw,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              frame_end,
    output logic [ADDR_W:0]   fb_addr,
    output logic [7:0]        fb_data,
    output logic              fb_valid,
    input  logic              fb_ready,
    output logic              front_bank,
    output logic              swap_pulse,
`ifdef FB_PIXEL_STATS_EN
    output logic [ADDR_W:0]   stat_written,
    output logic [ADDR_W:0]   stat_dropped,
`endif
    output fb_state_e         dbg_state
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = ADDR_W + 8;

    fb_state_e         state_q, state_d;
    logic              front_q, front_d;
    logic              pulse_q, pulse_d;
    logic              live_q;
    logic              fe_q;
    logic              s0_vld_q, s0_draw_q;
    logic [10:0]       s0_x_q, s0_y_q;
    logic [7:0]        s0_data_q;
    logic              s1_vld_q, s1_keep_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [7:0]        s1_data_q;
    logic [FW-1:0]     head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic              accept, fb_fire, fe_rise, pipe_empty, s0_keep;
    logic [ADDR_W-1:0] lin_addr;

    // Two slots stay free for the beats already in S0/S1, so S1 never stalls.
    assign in_ready   = (state_q == ST_RUN) && live_q && !fifo_full &&
                        (fifo_count <= CW'(FIFO_DEPTH - 3));
    assign accept     = in_valid && in_ready;
    assign fb_valid   = !fifo_empty;
    assign fb_fire    = fb_valid && fb_ready;
    assign fe_rise    = frame_end && !fe_q;
    assign pipe_empty = !s0_vld_q && !s1_vld_q && fifo_empty;
    assign s0_keep    = s0_draw_q && (32'(s0_x_q) < 32'(H_RES)) && (32'(s0_y_q) < 32'(V_RES));
    assign lin_addr   = ADDR_W'(32'(s0_y_q) * 32'(H_RES) + 32'(s0_x_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld_q  <= 1'b0;
            s0_draw_q <= 1'b0;
            s0_x_q    <= '0;
            s0_y_q    <= '0;
            s0_data_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_keep_q <= 1'b0;
            s1_addr_q <= '0;
            s1_data_q <= '0;
        end else begin
            s0_vld_q  <= accept;
            if (accept) begin
                s0_draw_q <= in_draw;
                s0_x_q    <= in_x;
                s0_y_q    <= in_y;
                s0_data_q <= in_data;
            end
            s1_vld_q  <= s0_vld_q;
            s1_keep_q <= s0_vld_q && s0_keep;
            if (s0_vld_q) begin
                s1_addr_q <= lin_addr;
                s1_data_q <= s0_data_q;
            end
        end
    end

    fb_write_fifo #(.W(FW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s1_keep_q),
        .wdata_i ({s1_addr_q, s1_data_q}),
        .pop_i   (fb_fire),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Writes always target the bank that is not being displayed.
    assign fb_addr    = fb_valid ? {~front_q, head[FW-1:8]} : '0;
    assign fb_data    = fb_valid ? head[7:0] : '0;
    assign front_bank = front_q;
    assign swap_pulse = pulse_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d = state_q;
        front_d = front_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_RUN:   if (fe_rise) state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_d = ST_SWAP;
            ST_SWAP: begin
                state_d = ST_RUN;
                front_d = ~front_q;
                pulse_d = 1'b1;
            end
            default:  state_d = ST_RUN;
        endcase
    end

    // fe_q starts high so a frame_end level already high out of reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            front_q <= 1'b0;
            pulse_q <= 1'b0;
            live_q  <= 1'b0;
            fe_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            pulse_q <= pulse_d;
            live_q  <= 1'b1;
            fe_q    <= frame_end;
        end
    end

`ifdef FB_PIXEL_STATS_EN
    localparam int SW = ADDR_W + 1;

    logic [SW-1:0] wr_cnt_q, drop_cnt_q, stat_wr_q, stat_drop_q;
    logic          in_oob;

    assign in_oob = in_draw && ((32'(in_x) >= 32'(H_RES)) || (32'(in_y) >= 32'(V_RES)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            drop_cnt_q  <= '0;
            stat_wr_q   <= '0;
            stat_drop_q <= '0;
        end else if (state_q == ST_SWAP) begin
            stat_wr_q   <= wr_cnt_q;
            stat_drop_q <= drop_cnt_q;
            wr_cnt_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (fb_fire && !(&wr_cnt_q))            wr_cnt_q   <= wr_cnt_q + SW'(1);
            if (accept && in_oob && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + SW'(1);
        end
    end

    assign stat_written = stat_wr_q;
    assign stat_dropped = stat_drop_q;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer against a transaction-level model of
// the pixel-to-framebuffer write stream and bank swapping.
module tb_fb_pixel_writer;
    import fb_pkg::*;

    localparam int H  = 800;
    localparam int V  = 600;
    localparam int D  = 8;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    in_data = '0;
    logic [10:0]   in_x = '0;
    logic [10:0]   in_y = '0;
    logic          in_draw = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          frame_end = 1'b1;
    logic [AW:0]   fb_addr;
    logic [7:0]    fb_data;
    logic          fb_valid;
    logic          fb_ready = 1'b1;
    logic          front_bank;
    logic          swap_pulse;
    fb_state_e     dbg_state;
`ifdef FB_PIXEL_STATS_EN
    logic [AW:0]   stat_written;
    logic [AW:0]   stat_dropped;
`endif

    always #5 clk = ~clk;

    fb_pixel_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_draw      (in_draw),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .frame_end    (frame_end),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_valid     (fb_valid),
        .fb_ready     (fb_ready),
        .front_bank   (front_bank),
        .swap_pulse   (swap_pulse),
`ifdef FB_PIXEL_STATS_EN
        .stat_written (stat_written),
        .stat_dropped (stat_dropped),
`endif
        .dbg_state    (dbg_state)
    );

    // Reference model: queue of expected writes {addr, data} and the cycle at
    // which each becomes visible on the framebuffer port.
    logic [26:0] exp_q[$];
    int          vis_q[$];
    int          cyc, last_acc, pulse_cyc, n_swaps;
    bit          live, draining, swapping, front_m, fe_prev, acc_g;
    int          wr_cnt, drop_cnt, stat_wr_m, stat_drop_m;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        vis_q.delete();
        cyc = 0; last_acc = -10; pulse_cyc = -1;
        live = 0; draining = 0; swapping = 0; front_m = 0; fe_prev = 1; acc_g = 0;
        wr_cnt = 0; drop_cnt = 0; stat_wr_m = 0; stat_drop_m = 0;
    endtask

    function automatic int vis_count();
        int n = 0;
        foreach (vis_q[i]) if (vis_q[i] <= cyc) n++;
        return n;
    endfunction

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic step();
        bit          exp_rdy, exp_vld, acc, pop, drained, v, dr, fe, rdy;
        int          xi, yi;
        logic [7:0]  dat;
        logic [19:0] ea;
        logic [7:0]  ed;
        @(negedge clk);
        exp_vld = (exp_q.size() > 0) && (vis_q[0] <= cyc);
        exp_rdy = live && !draining && !swapping && (vis_count() <= D - 3);
        ea = exp_vld ? {~front_m, exp_q[0][26:8]} : 20'h0;
        ed = exp_vld ? exp_q[0][7:0] : 8'h0;
        check("in_ready", in_ready, exp_rdy);
        check("fb_valid", fb_valid, exp_vld);
        check("fb_addr", fb_addr, ea);
        check("fb_data", fb_data, ed);
        check("front_bank", front_bank, front_m);
        check("swap_pulse", swap_pulse, cyc == pulse_cyc);
`ifdef FB_PIXEL_STATS_EN
        check("stat_written", stat_written, stat_wr_m);
        check("stat_dropped", stat_dropped, stat_drop_m);
`endif
        v = in_valid; dr = in_draw; xi = int'(in_x); yi = int'(in_y); dat = in_data;
        fe = frame_end; rdy = fb_ready;
        acc = v && exp_rdy;
        pop = exp_vld && rdy;
        drained = (exp_q.size() == 0) && (cyc >= last_acc + 3);
        @(posedge clk);
        if (pop) begin
            void'(exp_q.pop_front());
            void'(vis_q.pop_front());
            wr_cnt++;
        end
        if (acc) begin
            last_acc = cyc;
            if (dr && xi < H && yi < V) begin
                exp_q.push_back({19'(yi * H + xi), dat});
                vis_q.push_back(cyc + 3);
            end else if (dr) begin
                drop_cnt++;
            end
        end
        if (swapping) begin
            swapping = 0; front_m = ~front_m; pulse_cyc = cyc + 1; n_swaps++;
            stat_wr_m = wr_cnt; stat_drop_m = drop_cnt; wr_cnt = 0; drop_cnt = 0;
        end else if (draining) begin
            if (drained) begin draining = 0; swapping = 1; end
        end else if (fe && !fe_prev) begin
            draining = 1;
        end
        fe_prev = fe;
        live = 1;
        acc_g = acc;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_fb_valid", fb_valid, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_front_bank", front_bank, 0);
        check("rst_swap_pulse", swap_pulse, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_RUN));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input int x, input int y, input int d, input bit dr);
        in_x = 11'(x); in_y = 11'(y); in_data = 8'(d); in_draw = dr; in_valid = 1'b1;
        acc_g = 0;
        for (int i = 0; i < 64 && !acc_g; i++) step();
        check("send_accept", acc_g, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_swap(input string tag, input bit toggle_ready);
        int s0 = n_swaps;
        for (int i = 0; i < 200 && n_swaps == s0; i++) begin
            if (toggle_ready) fb_ready = ~fb_ready;
            step();
        end
        check(tag, n_swaps - s0, 1);
        fb_ready = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        n_swaps = 0;
        model_reset();
        #2;
        do_reset();

        // Directed beats with frame_end already high: no swap expected.
        send(0, 0, 5, 1);
        send(799, 0, 6, 1);
        send(0, 1, 7, 1);
        repeat (6) step();

        // Discarded beats: draw=0 and out of range.
        frame_end = 1'b0;
        send(3, 3, 9, 0);
        send(800, 10, 1, 1);
        repeat (6) step();

        // Memory stall with a continuous source.
        fb_ready = 1'b0;
        in_valid = 1'b1;
        in_draw = 1'b1;
        in_x = 11'($urandom_range(0, H - 1));
        in_y = 11'($urandom_range(0, V - 1));
        in_data = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc_g) begin
                in_x = 11'($urandom_range(0, H - 1));
                in_y = 11'($urandom_range(0, V - 1));
                in_data = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        fb_ready = 1'b1;
        repeat (12) step();

        // Frame end with five writes queued and a toggling memory ready.
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(10 + i, 20, 8'h40 + i, 1);
        repeat (3) step();
        frame_end = 1'b1;
        wait_swap("swap_after_drain", 1'b1);
        check("front_after_swap", front_bank, 1);
        frame_end = 1'b0;
        send(1, 2, 8'h11, 1);
        send(2, 2, 8'h12, 1);
        repeat (6) step();

        // Randomized traffic with occasional frame ends.
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || acc_g) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_x = 11'($urandom_range(0, 830));
                in_y = 11'($urandom_range(0, 620));
                in_draw = ($urandom_range(0, 7) != 0);
                in_data = 8'($urandom);
            end
            fb_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) frame_end = ~frame_end;
            step();
        end
        in_valid = 1'b0;
        fb_ready = 1'b1;
        repeat (12) step();

        // Last-row strip including the final pixel of the frame.
        frame_end = 1'b0;
        step();
        send(799, 598, 8'hA5, 1);
        for (int x = 780; x < 800; x++) send(x, 599, x, 1);
        frame_end = 1'b1;
        wait_swap("swap_after_strip", 1'b0);

        // Reset while draining with the front bank at 1.
        if (!front_m) begin
            frame_end = 1'b0;
            step();
            frame_end = 1'b1;
            wait_swap("swap_to_bank1", 1'b0);
        end
        frame_end = 1'b0;
        fb_ready = 1'b0;
        send(5, 5, 1, 1);
        send(6, 5, 2, 1);
        send(7, 5, 3, 1);
        step();
        frame_end = 1'b1;
        repeat (2) step();
        check("in_drain_before_reset", 32'(dbg_state), 32'(ST_DRAIN));
        fb_ready = 1'b1;
        do_reset();
        repeat (10) step();
        check("no_swap_after_reset", front_bank, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
